// File: rtl/bec_key_sched.sv
// Scalar-key sequencer for the bec ladder: loads the key as bus words, then
// presents it MSB-first on ki, one bit per next_key, and zeroizes at the end.
module bec_key_sched #(
    parameter int KEY_BITS = 163,
    parameter int WORD_W   = 32,
    parameter int NWORDS   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_wr,
    input  logic [2:0]  key_idx,
    input  logic [31:0] key_data,
    input  logic        start,
    input  logic        abort,
    input  logic        next_key,
    output logic        ki,
    output logic        busy,
    output logic        key_valid,
    output logic        done,
    output logic [7:0]  bit_cnt,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [KEY_BITS-1:0] key;
    logic [NWORDS-1:0]   wmask;
    logic [KEY_BITS-1:0] key_wdat;
    logic [NWORDS-1:0]   wmask_wdat;
    logic                idx_ok;

    // Key with the addressed word replaced; bits of word 5 above KEY_BITS drop out.
    always_comb begin
        key_wdat   = key;
        wmask_wdat = wmask;
        idx_ok     = int'(key_idx) < NWORDS;
        for (int b = 0; b < KEY_BITS; b++)
            if (int'(key_idx) == b / WORD_W) key_wdat[b] = key_data[b % WORD_W];
        for (int w = 0; w < NWORDS; w++)
            if (int'(key_idx) == w) wmask_wdat[w] = 1'b1;
    end

    assign ki        = key[KEY_BITS-1];
    assign busy      = (state == S_RUN);
    assign key_valid = &wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            key     <= '0;
            wmask   <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (abort) begin
                        key   <= '0;
                        wmask <= '0;
                    end else begin
                        // start is judged on the mask before any same-cycle write
                        if (start) begin
                            if (&wmask) begin
                                state   <= S_RUN;
                                bit_cnt <= '0;
                                err     <= 1'b0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        if (key_wr) begin
                            if (idx_ok) begin
                                key   <= key_wdat;
                                wmask <= wmask_wdat;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (key_wr) err <= 1'b1;
                    if (abort) begin
                        state   <= S_IDLE;
                        key     <= '0;
                        wmask   <= '0;
                        bit_cnt <= '0;
                    end else if (next_key) begin
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_cnt == 8'(KEY_BITS - 1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            key   <= '0;
                            wmask <= '0;
                        end else begin
                            key <= {key[KEY_BITS-2:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
                    if (key_wr) err <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bec_key_sched.sv
// Randomized bench for bec_key_sched: a word-level key model feeds expected ki
// bits and done events into queues that a negedge monitor consumes.
module tb_bec_key_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_wr = 1'b0;
    logic [2:0]  key_idx = '0;
    logic [31:0] key_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        next_key = 1'b0;
    logic        ki, busy, key_valid, done, err;
    logic [7:0]  bit_cnt;

    bec_key_sched dut (
        .clk(clk), .rst_n(rst_n), .key_wr(key_wr), .key_idx(key_idx),
        .key_data(key_data), .start(start), .abort(abort), .next_key(next_key),
        .ki(ki), .busy(busy), .key_valid(key_valid), .done(done),
        .bit_cnt(bit_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          exp_ki[$];
    int          exp_done[$];
    logic [31:0] w[6];

    // Key bit i of the scalar as assembled from the written words.
    function automatic bit kbit(int i);
        if (i >= 160) return w[5][i-160];
        return w[i/32][i%32];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a ki bit is consumed whenever bec pulses next_key in RUN.
    bit mb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && next_key) begin
                if (exp_ki.size() == 0) chk("ki_extra", {31'd0, next_key}, 0);
                else begin
                    mb = exp_ki.pop_front();
                    chk("ki", {31'd0, ki}, {31'd0, mb});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", {31'd0, done}, 0);
                else begin
                    void'(exp_done.pop_front());
                    chk("done_cnt", {24'd0, bit_cnt}, 163);
                    chk("done_busy", {31'd0, busy}, 0);
                    chk("done_kv", {31'd0, key_valid}, 0);
                    chk("done_ki", {31'd0, ki}, 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int idx, logic [31:0] d);
        key_wr   = 1'b1;
        key_idx  = 3'(idx);
        key_data = d;
        if (idx < 6) w[idx] = d;
        step();
        key_wr = 1'b0;
    endtask

    task automatic load_random();
        int s, o;
        s = ($urandom_range(0, 1) == 1) ? 5 : 1;
        o = $urandom_range(0, 5);
        wr($urandom_range(0, 5), $urandom);
        for (int i = 0; i < 6; i++) wr((i * s + o) % 6, $urandom);
    endtask

    task automatic do_start(bit ok);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, {31'd0, ok});
        chk("start_err", {31'd0, err}, {31'd0, !ok});
        if (ok) begin
            chk("start_cnt", {24'd0, bit_cnt}, 0);
            chk("start_ki", {31'd0, ki}, {31'd0, kbit(162)});
            for (int i = 162; i >= 0; i--) exp_ki.push_back(kbit(i));
        end
    endtask

    // Issue npulse next_key pulses with random gaps; optional abort / illegal write.
    task automatic run(int npulse, int abort_at, int wr_at);
        for (int k = 0; k < npulse; k++) begin
            repeat ($urandom_range(0, 2)) step();
            if (k == wr_at) begin
                key_wr = 1'b1; key_idx = 3'd2; key_data = 32'hFFFF_FFFF;
                step();
                key_wr = 1'b0;
                chk("run_wr_err", {31'd0, err}, 1);
            end
            if (k == abort_at) begin
                next_key = 1'b1; abort = 1'b1;
                step();
                next_key = 1'b0; abort = 1'b0;
                exp_ki.delete();
                chk("abort_busy", {31'd0, busy}, 0);
                chk("abort_cnt", {24'd0, bit_cnt}, 0);
                chk("abort_kv", {31'd0, key_valid}, 0);
                chk("abort_ki", {31'd0, ki}, 0);
                step();
                return;
            end
            if (k == 162) exp_done.push_back(1);
            next_key = 1'b1;
            step();
            next_key = 1'b0;
        end
        if (npulse == 163) begin
            step();
            chk("done_width", {31'd0, done}, 0);
            chk("post_cnt", {24'd0, bit_cnt}, 163);
            chk("post_leftover", exp_ki.size(), 0);
        end
    endtask

    initial begin
        step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ki", {31'd0, ki}, 0);
        chk("rst_kv", {31'd0, key_valid}, 0);
        chk("rst_misc", {22'd0, done, err, bit_cnt}, 0);
        rst_n = 1'b1;
        step();

        // Pattern key: A5 words, top three bits 101.
        for (int i = 0; i < 5; i++) wr(i, 32'hA5A5_A5A5);
        wr(5, 32'h5);
        chk("kv_full", {31'd0, key_valid}, 1);
        do_start(1);
        run(163, -1, -1);

        // Incomplete key rejected, then accepted; illegal write mid-run.
        for (int i = 0; i < 5; i++) wr(i, $urandom);
        chk("kv_partial", {31'd0, key_valid}, 0);
        do_start(0);
        wr(5, $urandom);
        do_start(1);
        run(163, -1, 30);

        // Abort together with next_key after 40 pulses.
        load_random();
        do_start(1);
        run(163, 40, -1);

        // Bad index in IDLE sets err; abort in IDLE clears the key.
        wr(6, 32'h1234);
        chk("idx_err", {31'd0, err}, 1);
        load_random();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_kv", {31'd0, key_valid}, 0);
        do_start(0);

        repeat (6) begin
            load_random();
            do_start(1);
            run(163, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 162)) : -1, -1);
        end

        // Asynchronous reset between edges mid-run.
        load_random();
        do_start(1);
        run(20, -1, -1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_ki.delete();
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ki", {31'd0, ki}, 0);
        chk("arst_cnt", {24'd0, bit_cnt}, 0);
        chk("arst_kv", {31'd0, key_valid}, 0);
        step();
        rst_n = 1'b1;
        step();
        do_start(0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
